traffic_phase_timer: RTL



---
 rtl/traffic_pkg.sv | 42 ++++
 rtl/tick_prescaler.sv | 47 ++++
 rtl/traffic_phase_timer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic-light system: lamp encodings, the light
// phase type and the lamp-bus decoder. The controllers' assertions reuse
// decode_lamps so that timer and checkers agree on what a legal phase is.
// -----------------------------------------------------------------------------
package traffic_pkg;

    // One-hot lamp encodings, identical on the highway and country-road buses
    localparam logic [2:0] LED_RED = 3'b001;
    localparam logic [2:0] LED_YEL = 3'b010;
    localparam logic [2:0] LED_GRN = 3'b100;

    typedef enum logic [1:0] {
        PH_HWG = 2'd0,
        PH_HWY = 2'd1,
        PH_CRG = 2'd2,
        PH_CRY = 2'd3
    } phase_t;

    typedef struct packed {
        logic   valid;
        phase_t ph;
    } decode_t;

    // Map the two lamp buses onto a phase; anything not listed is illegal
    // and reports valid=0 with the phase field parked at HWG.
    function automatic decode_t decode_lamps(input logic [2:0] hw, input logic [2:0] cr);
        decode_t r;
        r.valid = 1'b0;
        r.ph    = PH_HWG;
        case ({hw, cr})
            {LED_GRN, LED_RED}: begin r.valid = 1'b1; r.ph = PH_HWG; end
            {LED_YEL, LED_RED}: begin r.valid = 1'b1; r.ph = PH_HWY; end
            {LED_RED, LED_GRN}: begin r.valid = 1'b1; r.ph = PH_CRG; end
            {LED_RED, LED_YEL}: begin r.valid = 1'b1; r.ph = PH_CRY; end
            default:            begin r.valid = 1'b0; r.ph = PH_HWG; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-cycle tick every DIV clocks. The count runs
// 0..DIV-1 and tick is asserted while the count sits at DIV-1.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (count -> 0)
//   clear  in  restart the count at 0; suppresses tick this cycle
//   hold   in  freeze the count; suppresses tick this cycle (clear wins)
//   tick   out one-cycle tick, decoded from the count register
// tick is a decode of the count register only (no input-to-output logic
// beyond the two gating terms), so the caller sees it in the same cycle the
// count reaches DIV-1 and can act on it at that edge.
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int PS_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PS_W-1:0] cnt_r;
    logic            at_top_s;

    assign at_top_s = (cnt_r == PS_W'(DIV - 1));
    assign tick     = at_top_s && !clear && !hold;

    // Prescaler count: clear beats hold, otherwise wrap at DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {PS_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {PS_W{1'b0}};
        end else if (hold) begin
            cnt_r <= cnt_r;
        end else if (at_top_s) begin
            cnt_r <= {PS_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + PS_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// traffic_phase_timer
// Decodes the current light phase from the lamp buses, times it in
// one-second ticks and raises a one-cycle time_out when the phase duration
// has elapsed. An expired phase that is not advanced re-pulses on every tick.
// Illegal lamp combinations raise fault and freeze the timing.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   sensor   in  country-road vehicle present (synchronous to clk)
//   hw_led   in  [2:0] highway lamps, one-hot 001 red / 010 yellow / 100 green
//   cr_led   in  [2:0] country-road lamps, same encoding
//   time_out out one-cycle phase-expired strobe (registered)
//   phase    out [1:0] current phase 0 HWG, 1 HWY, 2 CRG, 3 CRY (registered)
//   fault    out illegal lamp combination seen last cycle (registered)
// Build option: SENSOR_EXTEND_EN adds parameter EXT_S and lets a waiting
// country-road vehicle stretch CRG one second at a time, up to EXT_S seconds
// per CRG entry.
// -----------------------------------------------------------------------------
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int HWG_S    = 25,
    parameter int HWY_S    = 4,
    parameter int CRG_S    = 10,
    parameter int CRY_S    = 4,
    parameter int CNT_W    = 8
`ifdef SENSOR_EXTEND_EN
    ,
    parameter int EXT_S    = 5
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor,
    input  logic [2:0] hw_led,
    input  logic [2:0] cr_led,
    output logic       time_out,
    output logic [1:0] phase,
    output logic       fault
);

    decode_t          dec_s;
    logic             entry_s;
    logic             tick_s;
    logic             expire_s;
    logic             extend_s;
    logic [CNT_W-1:0] dur_s;

    phase_t           phase_r;
    logic [CNT_W-1:0] cnt_r;
    logic             time_out_r;
    logic             fault_r;

    function automatic logic [CNT_W-1:0] phase_duration(input phase_t p);
        logic [CNT_W-1:0] d;
        case (p)
            PH_HWG:  d = CNT_W'(HWG_S);
            PH_HWY:  d = CNT_W'(HWY_S);
            PH_CRG:  d = CNT_W'(CRG_S);
            PH_CRY:  d = CNT_W'(CRY_S);
            default: d = CNT_W'(HWG_S);
        endcase
        return d;
    endfunction

    assign dec_s = decode_lamps(hw_led, cr_led);

    // A fault in the previous cycle forces re-entry even into the same phase,
    // so timing always restarts cleanly after an illegal interval.
    assign entry_s  = dec_s.valid && ((dec_s.ph != phase_r) || fault_r);
    assign dur_s    = phase_duration(dec_s.ph);
    assign expire_s = tick_s && (cnt_r <= CNT_W'(1));

    // Entry restarts the prescaler (discarding a coincident tick); an illegal
    // decode freezes it.
    tick_prescaler #(
        .DIV   (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (entry_s),
        .hold  (!dec_s.valid),
        .tick  (tick_s)
    );

`ifdef SENSOR_EXTEND_EN
    logic [CNT_W-1:0] ext_r;

    assign extend_s = (phase_r == PH_CRG) && sensor && (ext_r < CNT_W'(EXT_S));

    // Extension seconds already granted in the current CRG entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_r <= {CNT_W{1'b0}};
        end else if (entry_s) begin
            ext_r <= {CNT_W{1'b0}};
        end else if (expire_s && extend_s) begin
            ext_r <= ext_r + CNT_W'(1);
        end else begin
            ext_r <= ext_r;
        end
    end
`else
    logic sensor_unused_s;

    assign extend_s        = 1'b0;
    assign sensor_unused_s = sensor;
`endif

    // Phase register, seconds counter, strobe and fault flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r    <= PH_HWG;
            cnt_r      <= CNT_W'(HWG_S);
            time_out_r <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            fault_r    <= !dec_s.valid;
            time_out_r <= 1'b0;
            if (entry_s) begin
                phase_r <= dec_s.ph;
                cnt_r   <= dur_s;
            end else if (tick_s) begin
                if (cnt_r > CNT_W'(1)) begin
                    cnt_r <= cnt_r - CNT_W'(1);
                end else if (extend_s) begin
                    cnt_r <= CNT_W'(1);
                end else begin
                    // Stays at 0 when expired, so every later tick re-pulses
                    cnt_r      <= {CNT_W{1'b0}};
                    time_out_r <= 1'b1;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign time_out = time_out_r;
    assign phase    = phase_r;
    assign fault    = fault_r;

endmodule
